ahb_mem_slave: RTL and testbench

Parametrised AHB-Lite memory slave; successor of the fixed 256-word `slave_1`. Generalises memory depth and base address, adds programmable wait states, byte/halfword lane writes and a protocol-correct two-cycle ERROR response for out-of-range or misaligned accesses. Sits behind the AHB-Lite decoder/mux, one instance per memory region.

---
 rtl/ahb_mem_slave_pkg.sv | 58 +++++
 rtl/ahb_mem_slv_ram.sv | 25 ++
 rtl/ahb_mem_slave.sv | 133 +++++++++++++
 tb/tb_ahb_mem_slave.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mem_slave_pkg.sv
// Shared AHB-Lite types for the memory slave: bus enums, the slave FSM state
// enum and the little-endian byte-lane helper.
package ahb_mem_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } HTRANS_E;

  typedef enum logic [2:0] {
    HSIZE_BYTE      = 3'd0,
    HSIZE_HALF_WORD = 3'd1,
    HSIZE_WORD      = 3'd2,
    HSIZE_DWORD     = 3'd3,
    HSIZE_4WORD     = 3'd4,
    HSIZE_8WORD     = 3'd5,
    HSIZE_16WORD    = 3'd6,
    HSIZE_32WORD    = 3'd7
  } HSIZE_E;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } HBURST_E;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } HRESP_E;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } AHB_MEM_STATE_E;

  // Byte lanes touched by a transfer; lane 0 is bits [7:0] (little-endian).
  function automatic logic [3:0] lane_mask(input HSIZE_E size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE:      m = 4'b0001 << lo;
      HSIZE_HALF_WORD: m = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD:      m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_mem_slv_ram.sv
// Word-organised storage for the AHB memory slave: byte-enable synchronous
// write, asynchronous read on the same word index. Contents are never reset.
module ahb_mem_slv_ram #(
  parameter  int MEM_DEPTH = 256,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: address decode, error check, data-phase FSM and
// byte-lane write control around ahb_mem_slv_ram.
// Define AHB_MEM_SLAVE_WAIT_EN to honour WAIT_STATES; without it every OKAY
// transfer completes with zero wait states. ERROR responses always take two cycles.
module ahb_mem_slave
  import ahb_mem_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  HTRANS_E               HTRANS,
  input  logic                  HWRITE,
  input  HSIZE_E                HSIZE,
  input  HBURST_E               HBURST,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output HRESP_E                HRESP
);

  localparam int                    IDX_W        = $clog2(MEM_DEPTH);
  localparam int                    OFF_W        = IDX_W + 2;
  localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

  AHB_MEM_STATE_E   state;
  logic [OFF_W-1:0] addr_p1;
  logic             write_p1;
  HSIZE_E           size_p1;
  logic [ADDR_WIDTH-1:0] offset;
  logic             accept;
  logic             addr_err;
  logic             wait_done;
  logic             dp_complete;
  logic [3:0]       be;
  logic [31:0]      rdata;
  logic             unused_burst;

  // Burst type does not affect addressing; every beat carries its own HADDR.
  assign unused_burst = ^HBURST;

  assign offset = HADDR - BASE_ADDR;

  // HREADYOUT is high exactly when the current data phase (if any) can finish,
  // so including it keeps a stray HREADY from cutting a stall short.
  assign accept = HSEL && HREADY && HREADYOUT &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  // Out-of-region (including below base via wrap-around), misaligned or oversized.
  always_comb begin
    addr_err = (offset >= REGION_BYTES) ||
               (HSIZE > HSIZE_WORD) ||
               ((HSIZE == HSIZE_HALF_WORD) && HADDR[0]) ||
               ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  end

`ifdef AHB_MEM_SLAVE_WAIT_EN
  logic [2:0] cnt;
  assign wait_done = (cnt == 3'd0);
`else
  assign wait_done = 1'b1;
`endif

  assign dp_complete = (state == S_DATA) && wait_done && HREADY;
  assign be          = (dp_complete && write_p1) ? lane_mask(size_p1, addr_p1[1:0]) : 4'b0000;

  // Transfer FSM with registered HREADYOUT/HRESP; address phase captured into _p1.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      addr_p1   <= '0;
      write_p1  <= 1'b0;
      size_p1   <= HSIZE_BYTE;
`ifdef AHB_MEM_SLAVE_WAIT_EN
      cnt       <= 3'd0;
`endif
    end else begin
      if (state == S_ERR1) begin
        state     <= S_ERR2;
        HREADYOUT <= 1'b1;
        HRESP     <= HRESP_ERROR;
      end
`ifdef AHB_MEM_SLAVE_WAIT_EN
      else if ((state == S_DATA) && (cnt != 3'd0)) begin
        cnt       <= cnt - 3'd1;
        HREADYOUT <= (cnt == 3'd1);
      end
`endif
      else if (accept) begin
        addr_p1  <= offset[OFF_W-1:0];
        write_p1 <= HWRITE;
        size_p1  <= HSIZE;
        if (addr_err) begin
          state     <= S_ERR1;
          HREADYOUT <= 1'b0;
          HRESP     <= HRESP_ERROR;
        end else begin
          state <= S_DATA;
          HRESP <= HRESP_OKAY;
`ifdef AHB_MEM_SLAVE_WAIT_EN
          cnt       <= 3'(WAIT_STATES);
          HREADYOUT <= (WAIT_STATES == 0);
`else
          HREADYOUT <= 1'b1;
`endif
        end
      end else if (HREADY) begin
        state     <= S_IDLE;
        HREADYOUT <= 1'b1;
        HRESP     <= HRESP_OKAY;
      end
    end
  end

  ahb_mem_slv_ram #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
    .clk   (HCLK),
    .be    (be),
    .idx   (addr_p1[OFF_W-1:2]),
    .wdata (HWDATA),
    .rdata (rdata)
  );

  assign HRDATA = ((state == S_DATA) && !write_p1) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: the driver pushes the expected response
// of every accepted transfer; the monitor pops and checks it at data-phase end.
module tb_ahb_mem_slave;
  import ahb_mem_slave_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;
`ifdef AHB_MEM_SLAVE_WAIT_EN
  localparam int EXP_WS = 3;
`else
  localparam int EXP_WS = 0;
`endif

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b1;
  logic        HSEL    = 1'b0;
  logic        HWRITE  = 1'b0;
  logic        ext_rdy = 1'b1;
  logic [31:0] HADDR   = 32'h0;
  logic [31:0] HWDATA  = 32'h0;
  HTRANS_E     HTRANS  = HTRANS_IDLE;
  HSIZE_E      HSIZE   = HSIZE_WORD;
  HBURST_E     HBURST  = HBURST_INCR;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  HRESP_E      HRESP;
  logic        hready;

  assign hready = HREADYOUT & ext_rdy;

  ahb_mem_slave #(
    .ADDR_WIDTH (32),
    .MEM_DEPTH  (DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_STATES(3)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HWDATA   (HWDATA),
    .HREADY   (hready),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endfunction

  // Issue one address phase; returns one step after the edge that took it.
  task automatic xfer(input logic sel, input HTRANS_E tr, input logic wr, input HSIZE_E sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd_exp, input logic err);
    int guard;
    exp_t e;
    guard  = 0;
    HSEL   = sel;
    HTRANS = tr;
    HWRITE = wr;
    HSIZE  = sz;
    HADDR  = addr;
    @(negedge HCLK);
    while (!hready && guard < 50) begin
      guard++;
      @(negedge HCLK);
    end
    if (!hready) begin
      n_chk++;
      $display("FAIL accept_timeout: addr %h never saw HREADY=1", addr);
    end
    @(posedge HCLK);
    #1;
    if (sel && (tr == HTRANS_NONSEQ || tr == HTRANS_SEQ)) begin
      e.rd   = !wr;
      e.err  = err;
      e.data = rd_exp;
      exp_q.push_back(e);
    end
    HWDATA = wd;
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Monitor: follows data phases on the bus and checks against the queue.
  initial begin : monitor
    bit   in_dp;
    int   stall;
    exp_t e;
    in_dp = 0;
    stall = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        in_dp = 0;
        stall = 0;
        exp_q.delete();
      end else begin
        if (in_dp) begin
          if (!hready) begin
            stall++;
            if (exp_q.size() > 0)
              check("stall_resp", 32'(HRESP), exp_q[0].err ? 32'd1 : 32'd0);
            if (stall > 40) begin
              n_chk++;
              $display("FAIL dp_timeout: data phase stalled %0d cycles", stall);
              in_dp = 0;
              stall = 0;
            end
          end else begin
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_dp: data phase with no pending transfer");
            end else begin
              e = exp_q.pop_front();
              check("resp", 32'(HRESP), e.err ? 32'd1 : 32'd0);
              check("waits", 32'(stall), e.err ? 32'd1 : 32'(EXP_WS));
              if (e.rd || e.err) check("rdata", HRDATA, e.err ? 32'h0 : e.data);
            end
            in_dp = 0;
            stall = 0;
          end
        end else begin
          check("idle_hreadyout", 32'(HREADYOUT), 32'd1);
          check("idle_hresp", 32'(HRESP), 32'd0);
          check("idle_hrdata", HRDATA, 32'h0);
        end
        if (!in_dp && HSEL && hready && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ))
          in_dp = 1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    #1 HRESETn = 1'b0;
    idle(2);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    dut.u_ram.mem[0]  = 32'hCAFE_F00D;
    dut.u_ram.mem[8]  = 32'h0BAD_C0DE;
    dut.u_ram.mem[9]  = 32'h1234_5678;
    dut.u_ram.mem[10] = 32'h9ABC_DEF0;
    dut.u_ram.mem[12] = 32'h55AA_55AA;
    HRESETn = 1'b1;
    idle(2);

    // Back-to-back write then read of the same word.
    xfer(1, HTRANS_NONSEQ, 1, HSIZE_WORD, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 0);

    // Byte and halfword lane writes.
    xfer(1, HTRANS_NONSEQ, 1, HSIZE_WORD,      BASE + 32'h10, 32'h1122_3344, 32'h0, 0);
    xfer(1, HTRANS_NONSEQ, 1, HSIZE_BYTE,      BASE + 32'h13, 32'hAA00_0000, 32'h0, 0);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD,      BASE + 32'h10, 32'h0, 32'hAA22_3344, 0);
    xfer(1, HTRANS_NONSEQ, 1, HSIZE_HALF_WORD, BASE + 32'h12, 32'h5566_0000, 32'h0, 0);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD,      BASE + 32'h10, 32'h0, 32'h5566_3344, 0);

    // ERROR responses: out of range, misaligned, oversized, below base.
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD,      BASE + 32'h400, 32'h0, 32'h0, 1);
    xfer(1, HTRANS_NONSEQ, 1, HSIZE_WORD,      BASE + 32'h02,  32'hFFFF_FFFF, 32'h0, 1);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD,      BASE + 32'h00,  32'h0, 32'hCAFE_F00D, 0);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_HALF_WORD, BASE + 32'h11,  32'h0, 32'h0, 1);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_DWORD,     BASE + 32'h18,  32'h0, 32'h0, 1);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD,      BASE - 32'h4,   32'h0, 32'h0, 1);

    // Unselected NONSEQ write and BUSY between SEQ beats: no effect.
    xfer(0, HTRANS_NONSEQ, 1, HSIZE_WORD, BASE + 32'h20, 32'hFFFF_FFFF, 32'h0, 0);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, BASE + 32'h24, 32'h0, 32'h1234_5678, 0);
    xfer(1, HTRANS_BUSY,   1, HSIZE_WORD, BASE + 32'h28, 32'hFFFF_FFFF, 32'h0, 0);
    xfer(1, HTRANS_SEQ,    0, HSIZE_WORD, BASE + 32'h28, 32'h0, 32'h9ABC_DEF0, 0);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, BASE + 32'h20, 32'h0, 32'h0BAD_C0DE, 0);

    // Bus stalled by another slave: a pending write must not be accepted.
    idle(EXP_WS + 2);
    ext_rdy = 1'b0;
    HSEL    = 1'b1;
    HTRANS  = HTRANS_NONSEQ;
    HWRITE  = 1'b1;
    HSIZE   = HSIZE_WORD;
    HADDR   = BASE + 32'h24;
    HWDATA  = 32'hFFFF_FFFF;
    idle(3);
    HSEL    = 1'b0;
    HTRANS  = HTRANS_IDLE;
    HWRITE  = 1'b0;
    ext_rdy = 1'b1;
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, BASE + 32'h24, 32'h0, 32'h1234_5678, 0);

    // Reset in the middle of a write data phase aborts it.
    idle(EXP_WS + 2);
    xfer(1, HTRANS_NONSEQ, 1, HSIZE_WORD, BASE + 32'h30, 32'hFFFF_FFFF, 32'h0, 0);
    check("pre_rst_hreadyout", 32'(HREADYOUT), (EXP_WS != 0) ? 32'd0 : 32'd1);
    #1 HRESETn = 1'b0;
    #1;
    check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("midrst_hresp", 32'(HRESP), 32'd0);
    check("midrst_hrdata", HRDATA, 32'h0);
    idle(2);
    HRESETn = 1'b1;
    HWDATA  = 32'h0;
    idle(1);
    xfer(1, HTRANS_NONSEQ, 0, HSIZE_WORD, BASE + 32'h30, 32'h0, 32'h55AA_55AA, 0);

    idle(EXP_WS + 4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
